// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM states, the queued command record
// and the data word returned by a timed-out transfer.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 5;
    localparam int APB_DATA_WIDTH = 32;

    localparam logic [31:0] APB_TIMEOUT_DATA = 32'hBADC_0FFE;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_mst_state_t;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with extra-MSB pointers; full/empty come from the MSB compare.
// Entry type defaults to apb_cmd_t and is overridden by the bridge to match its widths.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = apb_cmd_t
) (
    input  logic   pclk,
    input  logic   presetn,
    input  logic   i_push,
    input  entry_t i_push_data,
    input  logic   i_pop,
    output entry_t o_head,
    output logic   o_full,
    output logic   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    entry_t         r_mem [DEPTH];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            if (i_pop)  r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge pclk) begin
        if (i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command in, APB SETUP/ACCESS out, valid/ready response back; one transfer at a time.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    apb_mst_state_t        r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
    logic                  r_pwrite, w_pwrite_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic                  r_rsp_err, w_rsp_err_nxt;

    logic w_push, w_pop, w_full, w_empty, w_timeout;
    cmd_t w_push_data, w_head;

    assign cmd_ready   = !w_full && presetn;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_push_data = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    apb_cmd_fifo #(
        .DEPTH   (CMD_DEPTH),
        .entry_t (cmd_t)
    ) u_cmd_fifo (
        .pclk        (pclk),
        .presetn     (presetn),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Counts ACCESS cycles already spent waiting; the last allowed one fires the timeout.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                         r_to_cnt <= '0;
        else if (r_state == SETUP)            r_to_cnt <= '0;
        else if (r_state == ACCESS && !pready) r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: every next-state value is defaulted first so no branch can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_pop           = 1'b0;

        if (r_rsp_valid && rsp_ready) w_rsp_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_empty && (!r_rsp_valid || rsp_ready)) begin
                    w_pop        = 1'b1;
                    w_state_nxt  = SETUP;
                    w_paddr_nxt  = w_head.addr;
                    w_pwrite_nxt = w_head.write;
                    w_pwdata_nxt = w_head.wdata;
                end
            end
            SETUP: w_state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = pslverr;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
                end else if (w_timeout) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = DATA_WIDTH'(APB_TIMEOUT_DATA);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign psel      = (r_state != IDLE);
    assign penable   = (r_state == ACCESS);
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = !w_empty || (r_state != IDLE) || r_rsp_valid;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a behavioural APB slave and a transaction-level
// model: responses in push order, occupancy-derived cmd_ready/busy, APB protocol rules.
module tb_apb_master_bridge;

    localparam int DEPTH = 4;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [4:0]  paddr;
    logic [31:0] pwdata, prdata;

    always #5 pclk = ~pclk;

    apb_master_bridge dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    // ---------------- behavioural APB slave ----------------
    logic [31:0] slv_mem [32];
    int          waits = 0;
    int          wait_cnt;
    logic        tie_low = 1'b0;
    logic        err_en = 1'b0;
    logic [4:0]  err_addr = 5'd7;

    assign pready  = psel && penable && !tie_low && (wait_cnt >= waits);
    assign prdata  = slv_mem[paddr];
    assign pslverr = psel && penable && err_en && (paddr == err_addr);

    always @(posedge pclk or negedge presetn) begin
        if (!presetn || !penable) wait_cnt <= 0;
        else if (!pready)         wait_cnt <= wait_cnt + 1;
        if (presetn && psel && penable && pready && pwrite && !pslverr)
            slv_mem[paddr] <= pwdata;
    end

    // ---------------- scoreboard / model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        rsp_log[$];
    logic [31:0] mdl_mem [32];
    int          n_cmp = 0, n_fail = 0;
    int          n_push = 0, n_setup = 0, n_setup_all = 0;
    int          rsp_count = 0, pen_cnt = 0;
    logic        timeout_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            slv_mem[i] = 32'h1000_0000 + i;
            mdl_mem[i] = 32'h1000_0000 + i;
        end
    end

    // Compare process: all outputs checked on every falling edge.
    initial begin
        logic        p_psel, p_pen, p_pready, p_pwrite, p_rv, p_rr, p_rerr;
        logic [4:0]  p_addr;
        logic [31:0] p_wdata, p_rdata;
        rsp_t        e;
        logic        err;
        {p_psel, p_pen, p_pready, p_pwrite, p_rv, p_rr, p_rerr} = '0;
        p_addr = '0; p_wdata = '0; p_rdata = '0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                check("rst_outputs", {27'd0, psel, penable, rsp_valid, cmd_ready, busy}, 32'd0);
                exp_q.delete();
                n_push = 0; n_setup = 0;
                {p_psel, p_pen, p_pready, p_rv, p_rr} = '0;
            end else begin
                if (psel && !penable) begin n_setup++; n_setup_all++; pen_cnt = 0; end
                if (penable) pen_cnt++;
                check("cmd_ready", {31'd0, cmd_ready}, {31'd0, (n_push - n_setup) < DEPTH});
                check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
                if (penable) check("penable_needs_psel", {31'd0, psel}, 32'd1);
                if (psel && !p_psel) check("setup_first", {31'd0, penable}, 32'd0);
                if (p_psel && !p_pen) check("setup_to_access", {30'd0, psel, penable}, 32'd3);
                if (p_pen && p_pready) check("idle_gap", {31'd0, psel}, 32'd0);
                if (p_psel && psel) begin
                    check("paddr_stable", {27'd0, paddr}, {27'd0, p_addr});
                    check("pwrite_stable", {31'd0, pwrite}, {31'd0, p_pwrite});
                    check("pwdata_stable", pwdata, p_wdata);
                end
                if (p_rv && !p_rr) begin
                    check("rsp_held", {31'd0, rsp_valid}, 32'd1);
                    check("rsp_rdata_held", rsp_rdata, p_rdata);
                    check("rsp_err_held", {31'd0, rsp_err}, {31'd0, p_rerr});
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                    end else if (rsp_ready) begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        rsp_log.push_back('{rsp_rdata, rsp_err});
                        rsp_count++;
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    n_push++;
                    err = err_en && (cmd_addr == err_addr);
                    if (timeout_mode)   exp_q.push_back('{32'hBADC_0FFE, 1'b1});
                    else if (cmd_write) begin
                        if (!err) mdl_mem[cmd_addr] = cmd_wdata;
                        exp_q.push_back('{32'd0, err});
                    end else            exp_q.push_back('{mdl_mem[cmd_addr], err});
                end
                {p_psel, p_pen, p_pready, p_pwrite, p_rv, p_rr, p_rerr} =
                    {psel, penable, pready, pwrite, rsp_valid, rsp_ready, rsp_err};
                p_addr = paddr; p_wdata = pwdata; p_rdata = rsp_rdata;
            end
        end
    end

    // ---------------- drivers (called at posedge + #1) ----------------
    task automatic push(input logic w, input logic [4:0] a, input logic [31:0] d);
        int k = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        do begin @(negedge pclk); k++; end while (!cmd_ready && k < 100);
        if (!cmd_ready) check("push_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int k = 0;
        while (rsp_count < target && k < 200) begin @(posedge pclk); #1; k++; end
        check("rsp_wait", rsp_count, target);
        @(posedge pclk); #1;
    endtask

    initial begin
        int k, base, s0;
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base, s0;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        #2;
        check("reset_psel_pen_rv", {29'd0, psel, penable, rsp_valid}, 32'd0);
        check("reset_cmd_ready_busy", {30'd0, cmd_ready, busy}, 32'd0);
        check("reset_paddr_pwdata", {paddr, pwdata[26:0]}, 32'd0);
        #10 presetn = 1'b1;
        @(posedge pclk); #1;

        // 1: write then read, latency and SETUP/ACCESS ordering
        push(1'b1, 5'd3, 32'hA5A5_0001);
        k = 0;
        do begin
            @(posedge pclk); #1; k++;
            if (k == 1) check("t1_setup", {24'd0, psel, penable, 1'b0, paddr}, {24'd0, 3'b100, 5'd3});
            if (k == 2) check("t1_access", {30'd0, psel, penable}, 32'd3);
        end while (!rsp_valid && k < 10);
        check("t1_latency", k, 3);
        wait_rsp(1);
        check("t1_wr_rdata", rsp_log[0].rdata, 32'd0);
        check("t1_wr_err", {31'd0, rsp_log[0].err}, 32'd0);
        push(1'b0, 5'd3, 32'd0);
        wait_rsp(2);
        check("t1_rd_rdata", rsp_log[1].rdata, 32'hA5A5_0001);
        check("t1_rd_err", {31'd0, rsp_log[1].err}, 32'd0);

        // 2: three wait states
        waits = 3;
        push(1'b1, 5'd9, 32'h0BAD_F00D);
        wait_rsp(3);
        check("t2_penable_cycles", pen_cnt, 4);
        check("t2_one_rsp", rsp_log.size(), 3);
        waits = 0;

        // 3: backpressure, six reads
        rsp_ready = 1'b0;
        s0 = n_setup_all; base = rsp_count;
        for (int i = 0; i < 5; i++) push(1'b0, 5'(8 + i), 32'd0);
        repeat (4) @(posedge pclk); #1;
        check("t3_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        check("t3_one_transfer", n_setup_all - s0, 1);
        check("t3_rsp_held", {30'd0, rsp_valid, busy}, 32'd3);
        rsp_ready = 1'b1;
        push(1'b0, 5'd13, 32'd0);
        wait_rsp(base + 6);
        check("t3_transfers", n_setup_all - s0, 6);
        check("t3_first_rdata", rsp_log[base].rdata, 32'h1000_0008);
        check("t3_last_rdata", rsp_log[base + 5].rdata, 32'h1000_000D);

        // 4: slave error on addr 7, then clean traffic
        err_en = 1'b1; base = rsp_count;
        push(1'b0, 5'd7, 32'd0);
        push(1'b1, 5'd2, 32'h0000_BEEF);
        push(1'b0, 5'd2, 32'd0);
        wait_rsp(base + 3);
        check("t4_err_read", {31'd0, rsp_log[base].err}, 32'd1);
        check("t4_next_ok", {31'd0, rsp_log[base + 1].err}, 32'd0);
        check("t4_readback", rsp_log[base + 2].rdata, 32'h0000_BEEF);
        err_en = 1'b0;

        // 5: reset in the middle of ACCESS
        waits = 10; base = rsp_count;
        push(1'b0, 5'd1, 32'd0);
        k = 0;
        while (!penable && k < 20) begin @(posedge pclk); #1; k++; end
        check("t5_in_access", {31'd0, penable}, 32'd1);
        #3 presetn = 1'b0;
        #1 check("t5_async_drop", {29'd0, psel, penable, rsp_valid}, 32'd0);
        repeat (2) @(posedge pclk); #1;
        presetn = 1'b1;
        waits = 0;
        repeat (3) @(posedge pclk); #1;
        check("t5_idle_after", {29'd0, busy, rsp_valid, psel}, 32'd0);
        check("t5_no_stale_rsp", rsp_count, base);

`ifdef APB_MASTER_TIMEOUT_EN
        // 6: pready never rises
        tie_low = 1'b1; timeout_mode = 1'b1; base = rsp_count;
        push(1'b0, 5'd4, 32'd0);
        timeout_mode = 1'b0;
        wait_rsp(base + 1);
        check("t6_access_cycles", pen_cnt, 16);
        check("t6_err", {31'd0, rsp_log[base].err}, 32'd1);
        check("t6_rdata", rsp_log[base].rdata, 32'hBADC_0FFE);
        tie_low = 1'b0;
`endif

        repeat (3) @(posedge pclk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
